// File: rtl/mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// mem_loader_pkg
//   Shared definitions for the memory debug loader:
//     - state_t      : loader FSM states
//     - DEF_*        : default address/data widths
//     - chk_update() : running checksum step, rotate-left-by-one then add,
//                      evaluated modulo 2^width
// -----------------------------------------------------------------------------
package mem_loader_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 64;

    // Widest data word the checksum helper can handle.
    localparam int CHK_MAX_W = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_DRAIN,
        ST_FINISH
    } state_t;

    // The helper is written for a fixed maximum width so that modules with any
    // DATA_WIDTH up to CHK_MAX_W can share it; callers zero-extend their
    // operands and truncate the result back to their own width.
    function automatic logic [CHK_MAX_W-1:0] chk_update(
        input logic [CHK_MAX_W-1:0] acc,
        input logic [CHK_MAX_W-1:0] word,
        input int                   width
    );
        logic [CHK_MAX_W-1:0] mask;
        logic [CHK_MAX_W-1:0] rot;
        mask = (CHK_MAX_W'(1) << width) - CHK_MAX_W'(1);
        rot  = ((acc << 1) | (acc >> (width - 1))) & mask;
        return (rot + word) & mask;
    endfunction

endpackage

// File: rtl/mem_loader_rdpipe.sv
// -----------------------------------------------------------------------------
// mem_loader_rdpipe
//   Read-side tracking for the verify phase. A RD_LATENCY-deep valid shift
//   register follows each issued read address so that the matching memory
//   word is recognised when it returns; every recognised word is folded into
//   the read-side checksum.
//
// Ports
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : synchronous clear of pipe and checksum (new run)
//   tag_in       : a real read address is on the memory port this cycle
//   rdata        : memory read data
//   vld_out      : rdata carries a tagged (expected) word this cycle
//   chk_read     : running checksum over all consumed read words
// -----------------------------------------------------------------------------
module mem_loader_rdpipe
    import mem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  tag_in,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  vld_out,
    output logic [DATA_WIDTH-1:0] chk_read
);

    logic [RD_LATENCY-1:0] vld_p;

    function automatic logic [DATA_WIDTH-1:0] chk_next(
        input logic [DATA_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0] word
    );
        return DATA_WIDTH'(chk_update(CHK_MAX_W'(acc), CHK_MAX_W'(word), DATA_WIDTH));
    endfunction

    assign vld_out = vld_p[RD_LATENCY-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p    <= '0;
            chk_read <= '0;
        end else if (clear) begin
            vld_p    <= '0;
            chk_read <= '0;
        end else begin
            // stage 0 takes the tag of the address presented this cycle
            vld_p[0] <= tag_in;
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
            // last stage lines up with the returning word
            if (vld_p[RD_LATENCY-1]) begin
                chk_read <= chk_next(chk_read, rdata);
            end
        end
    end

endmodule

// File: rtl/mem_debug_loader.sv
// -----------------------------------------------------------------------------
// mem_debug_loader
//   Host-side initiator for the core's memory debug port. Streams a block of
//   host words into memory through the setup_mem write path, then (when
//   MEM_LOADER_VERIFY_EN is defined) reads the same range back through the
//   verify_mem path and compares checksums. The core is held disabled
//   (core_en=0) while the loader is busy.
//
// Build option
//   MEM_LOADER_VERIFY_EN : defined   -> LOAD, VERIFY, DRAIN, FINISH
//                          undefined -> LOAD goes straight to FINISH,
//                                       verify_mem and error tied low,
//                                       mem_rdata_in ignored
//
// Ports
//   clk, reset     : clock, asynchronous active-high reset
//   start          : one-cycle run request, taken only when idle
//   base_addr      : first memory address (latched on start)
//   word_count     : words to transfer, 0..2^ADDR_WIDTH (latched on start)
//   host_valid/ready/data : host word stream handshake
//   mem_addr_out   : memory address to the core
//   mem_wdata_out  : memory write data to the core
//   setup_mem      : one-cycle write strobe per word
//   verify_mem     : read-port select during verify
//   mem_rdata_in   : memory read data from the core
//   core_en        : core enable, low while busy
//   busy           : loader not idle
//   done           : one-cycle completion pulse
//   error          : checksum mismatch of the last run (sticky)
//   checksum       : load-side checksum of the last run
// -----------------------------------------------------------------------------
module mem_debug_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  host_valid,
    output logic                  host_ready,
    input  logic [DATA_WIDTH-1:0] host_data,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic [DATA_WIDTH-1:0] mem_wdata_out,
    output logic                  setup_mem,
    output logic                  verify_mem,
    input  logic [DATA_WIDTH-1:0] mem_rdata_in,
    output logic                  core_en,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] checksum
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [ADDR_WIDTH:0]   count_r;
    logic [ADDR_WIDTH:0]   idx;
    logic [DATA_WIDTH-1:0] chk_load;
    logic                  start_acc;
    logic                  vld_out;
    logic [DATA_WIDTH-1:0] chk_read;

    function automatic logic [DATA_WIDTH-1:0] chk_next(
        input logic [DATA_WIDTH-1:0] acc,
        input logic [DATA_WIDTH-1:0] word
    );
        return DATA_WIDTH'(chk_update(CHK_MAX_W'(acc), CHK_MAX_W'(word), DATA_WIDTH));
    endfunction

    assign start_acc = (state == ST_IDLE) && start;

`ifdef MEM_LOADER_VERIFY_EN
    // rd_tag marks cycles whose address is a real read; verify_mem alone is
    // not enough because it stays high through the drain cycles.
    logic                rd_tag;
    logic [ADDR_WIDTH:0] rd_cnt;

    mem_loader_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rdpipe (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_acc),
        .tag_in   (rd_tag),
        .rdata    (mem_rdata_in),
        .vld_out  (vld_out),
        .chk_read (chk_read)
    );
`else
    logic unused_rd;

    mem_loader_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_rdpipe (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_acc),
        .tag_in   (1'b0),
        .rdata    ('0),
        .vld_out  (vld_out),
        .chk_read (chk_read)
    );

    assign verify_mem = 1'b0;
    assign error      = 1'b0;
    assign unused_rd  = ^{mem_rdata_in, chk_read, vld_out};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            base_r        <= '0;
            count_r       <= '0;
            idx           <= '0;
            chk_load      <= '0;
            host_ready    <= 1'b0;
            setup_mem     <= 1'b0;
            mem_addr_out  <= '0;
            mem_wdata_out <= '0;
            core_en       <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            checksum      <= '0;
`ifdef MEM_LOADER_VERIFY_EN
            verify_mem    <= 1'b0;
            error         <= 1'b0;
            rd_tag        <= 1'b0;
            rd_cnt        <= '0;
`endif
        end else begin
            setup_mem <= 1'b0;
            done      <= 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
            rd_tag    <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_r   <= base_addr;
                        count_r  <= word_count;
                        idx      <= '0;
                        chk_load <= '0;
                        checksum <= '0;
                        busy     <= 1'b1;
                        core_en  <= 1'b0;
`ifdef MEM_LOADER_VERIFY_EN
                        error    <= 1'b0;
                        rd_cnt   <= '0;
`endif
                        if (word_count == '0) begin
                            state <= ST_FINISH;
                        end else begin
                            state      <= ST_LOAD;
                            host_ready <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (host_valid && host_ready) begin
                        setup_mem     <= 1'b1;
                        mem_addr_out  <= base_r + idx[ADDR_WIDTH-1:0];
                        mem_wdata_out <= host_data;
                        chk_load      <= chk_next(chk_load, host_data);
                        if (idx == count_r - 1'b1) begin
                            host_ready <= 1'b0;
                            idx        <= '0;
`ifdef MEM_LOADER_VERIFY_EN
                            state      <= ST_VERIFY;
`else
                            state      <= ST_FINISH;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

`ifdef MEM_LOADER_VERIFY_EN
                // Entered in the cycle the final write strobe is on the port;
                // the registered read address therefore follows it directly.
                ST_VERIFY: begin
                    verify_mem   <= 1'b1;
                    rd_tag       <= 1'b1;
                    mem_addr_out <= base_r + idx[ADDR_WIDTH-1:0];
                    if (idx == count_r - 1'b1) begin
                        state <= ST_DRAIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (vld_out && (rd_cnt == count_r - 1'b1)) begin
                        verify_mem <= 1'b0;
                        state      <= ST_FINISH;
                    end
                end
`endif

                ST_FINISH: begin
                    done     <= 1'b1;
                    checksum <= chk_load;
                    busy     <= 1'b0;
                    core_en  <= 1'b1;
                    state    <= ST_IDLE;
`ifdef MEM_LOADER_VERIFY_EN
                    error    <= (chk_read != chk_load);
`endif
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

`ifdef MEM_LOADER_VERIFY_EN
            if (vld_out) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_debug_loader.sv
`timescale 1ns/1ps
module tb_mem_debug_loader;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam int RL = 1;
`ifdef MEM_LOADER_VERIFY_EN
    localparam bit VEN = 1'b1;
`else
    localparam bit VEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          host_valid;
    logic          host_ready;
    logic [DW-1:0] host_data;
    logic [AW-1:0] mem_addr_out;
    logic [DW-1:0] mem_wdata_out;
    logic          setup_mem;
    logic          verify_mem;
    logic [DW-1:0] mem_rdata_in;
    logic          core_en;
    logic          busy;
    logic          done;
    logic          error;
    logic [DW-1:0] checksum;

    always #5 clk = ~clk;

    mem_debug_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (RL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .host_data     (host_data),
        .mem_addr_out  (mem_addr_out),
        .mem_wdata_out (mem_wdata_out),
        .setup_mem     (setup_mem),
        .verify_mem    (verify_mem),
        .mem_rdata_in  (mem_rdata_in),
        .core_en       (core_en),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .checksum      (checksum)
    );

    // Ideal one-cycle memory; optional bit-0 corruption of address 2 on read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          flip;
    always @(posedge clk) begin
        if (setup_mem) mem[mem_addr_out] <= mem_wdata_out;
        if (verify_mem)
            mem_rdata_in <= mem[mem_addr_out] ^ ((flip && mem_addr_out == AW'(2)) ? 64'd1 : 64'd0);
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [AW-1:0]      base;
        logic [AW:0]        cnt;
        logic [3:0][DW-1:0] w;
        logic [1:0]         gap;
        logic               noisy;
        logic               flp;
        logic [DW-1:0]      exp_chk;
        logic               exp_err;
    } vec_t;

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    logic [DW-1:0] words[$];
    vec_t          vt[7];

    int checks = 0;
    int errors = 0;
    int cyc, n_wr, n_v, n_done, done_at, last_wr_cyc, first_v_cyc, overlap;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_chk(input logic [DW-1:0] acc, input logic [DW-1:0] w);
        return {acc[DW-2:0], acc[DW-1]} + w;
    endfunction

    // Advance one clock and score whatever the DUT put on its outputs.
    task automatic step();
        wr_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (setup_mem) begin
            n_wr++;
            last_wr_cyc = cyc;
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_extra addr=%0h data=%0h required=no write", mem_addr_out, mem_wdata_out);
            end else begin
                e = exp_wr.pop_front();
                chk("wr_addr", DW'(mem_addr_out), DW'(e.addr));
                chk("wr_data", mem_wdata_out, e.data);
            end
        end
        if (verify_mem) begin
            if (n_v == 0) first_v_cyc = cyc;
            n_v++;
            if (exp_rd.size() > 0) chk("rd_addr", DW'(mem_addr_out), DW'(exp_rd.pop_front()));
        end
        if (setup_mem && verify_mem) overlap++;
        if (done) begin
            n_done++;
            done_at = cyc;
        end
    endtask

    task automatic run_core(input logic [AW-1:0] base, input int cnt, input int gap_mode,
                            input bit noisy, input bit flp, input logic [DW-1:0] exp_chk,
                            input bit exp_err);
        int k;
        int p;
        logic [AW-1:0] a;
        flip = flp;
        cyc = 0; n_wr = 0; n_v = 0; n_done = 0; done_at = -1;
        last_wr_cyc = -1; first_v_cyc = -1; overlap = 0;
        exp_wr.delete();
        exp_rd.delete();
        if (VEN) begin
            for (int i = 0; i < cnt; i++) begin
                a = base + AW'(i);
                exp_rd.push_back(a);
            end
        end
        base_addr  = base;
        word_count = (AW+1)'(cnt);
        start      = 1'b1;
        host_valid = noisy;
        host_data  = '1;
        step();
        start = 1'b0;
        chk("busy_after_start", DW'(busy), 64'd1);
        chk("core_en_after_start", DW'(core_en), 64'd0);
        chk("error_cleared", DW'(error), 64'd0);
        chk("checksum_cleared", checksum, 64'd0);

        k = 0;
        p = 0;
        while (n_done == 0 && cyc < 400) begin
            if (k < cnt) begin
                case (gap_mode)
                    0:       host_valid = 1'b1;
                    1:       host_valid = (p % 3 == 0);
                    default: host_valid = 1'($urandom_range(0, 1));
                endcase
                host_data = words[k];
            end else begin
                host_valid = noisy;
                host_data  = '1;
            end
            // a second start mid-run must be ignored
            start      = noisy && (cyc == 2);
            base_addr  = ~base;
            word_count = (AW+1)'(1);
            if (host_valid && host_ready && k < cnt) begin
                a = base + AW'(k);
                exp_wr.push_back('{addr: a, data: words[k]});
                k++;
            end
            if (host_ready) p++;
            step();
        end
        start      = 1'b0;
        host_valid = 1'b0;

        if (n_done == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no done required=done within 400 cycles");
        end else begin
            chk("checksum", checksum, exp_chk);
            chk("error", DW'(error), DW'(exp_err & VEN));
            chk("busy_at_done", DW'(busy), 64'd0);
            chk("core_en_at_done", DW'(core_en), 64'd1);
            chk("host_ready_at_done", DW'(host_ready), 64'd0);
            chk("n_writes", DW'(n_wr), DW'(cnt));
            chk("wr_left", DW'(exp_wr.size()), 64'd0);
            chk("n_verify_cycles", DW'(n_v), (VEN && cnt > 0) ? DW'(cnt + RL) : 64'd0);
            chk("overlap", DW'(overlap), 64'd0);
            if (VEN && cnt > 0) chk("first_verify_cycle", DW'(first_v_cyc), DW'(last_wr_cyc + 1));
            if (cnt == 0) chk("done_latency_cnt0", DW'(done_at), 64'd2);
        end
        step();
        chk("done_one_cycle", DW'(done), 64'd0);
        chk("n_done", DW'(n_done), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int k;
        int guard;
        logic [AW-1:0] rb;
        logic [DW-1:0] m;

        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        host_valid = 1'b0; host_data = '0; flip = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_host_ready", DW'(host_ready), 64'd0);
        chk("rst_setup_mem", DW'(setup_mem), 64'd0);
        chk("rst_verify_mem", DW'(verify_mem), 64'd0);
        chk("rst_addr", DW'(mem_addr_out), 64'd0);
        chk("rst_wdata", mem_wdata_out, 64'd0);
        chk("rst_core_en", DW'(core_en), 64'd1);
        chk("rst_busy", DW'(busy), 64'd0);
        chk("rst_done", DW'(done), 64'd0);
        chk("rst_error", DW'(error), 64'd0);
        chk("rst_checksum", checksum, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        //        base     cnt  words (w[0] first)                         gap noisy flip checksum     err
        vt[0] = '{10'h000, 11'd4, {64'd4, 64'd3, 64'd2, 64'd1},             2'd0, 1'b0, 1'b0, 64'h1A,  1'b0};
        vt[1] = '{10'h3FE, 11'd4, {64'h40, 64'h30, 64'h20, 64'h10},        2'd0, 1'b0, 1'b0, 64'h1A0, 1'b0};
        vt[2] = '{10'h000, 11'd4, {64'd4, 64'd3, 64'd2, 64'd1},             2'd0, 1'b0, 1'b1, 64'h1A,  1'b1};
        vt[3] = '{10'h000, 11'd4, {64'd4, 64'd3, 64'd2, 64'd1},             2'd1, 1'b0, 1'b0, 64'h1A,  1'b0};
        vt[4] = '{10'h123, 11'd0, {64'd0, 64'd0, 64'd0, 64'd0},             2'd0, 1'b0, 1'b0, 64'h0,   1'b0};
        vt[5] = '{10'h100, 11'd2, {64'd0, 64'd0, 64'd1, 64'h8000_0000_0000_0001}, 2'd0, 1'b1, 1'b0, 64'h4, 1'b0};
        vt[6] = '{10'h3FF, 11'd1, {64'd0, 64'd0, 64'd0, 64'hDEAD_BEEF},     2'd1, 1'b0, 1'b0, 64'hDEAD_BEEF, 1'b0};

        for (int i = 0; i < 7; i++) begin
            words.delete();
            for (int j = 0; j < int'(vt[i].cnt); j++) words.push_back(vt[i].w[j]);
            run_core(vt[i].base, int'(vt[i].cnt), int'(vt[i].gap), vt[i].noisy, vt[i].flp,
                     vt[i].exp_chk, vt[i].exp_err);
        end

        // Reset asserted after two of four words.
        flip = 1'b0;
        cyc = 0; n_wr = 0; n_v = 0; n_done = 0; overlap = 0;
        exp_wr.delete();
        exp_rd.delete();
        base_addr = '0; word_count = 11'd4; start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        guard = 0;
        while (k < 2 && guard < 20) begin
            host_valid = 1'b1;
            host_data  = 64'hA0 + DW'(k);
            if (host_ready) begin
                exp_wr.push_back('{addr: AW'(k), data: host_data});
                k++;
            end
            step();
            guard++;
        end
        host_valid = 1'b0;
        chk("rst_seq_words", DW'(k), 64'd2);
        chk("rst_seq_busy_before", DW'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_host_ready", DW'(host_ready), 64'd0);
        chk("midrst_setup_mem", DW'(setup_mem), 64'd0);
        chk("midrst_verify_mem", DW'(verify_mem), 64'd0);
        chk("midrst_addr", DW'(mem_addr_out), 64'd0);
        chk("midrst_wdata", mem_wdata_out, 64'd0);
        chk("midrst_core_en", DW'(core_en), 64'd1);
        chk("midrst_busy", DW'(busy), 64'd0);
        chk("midrst_done", DW'(done), 64'd0);
        chk("midrst_checksum", checksum, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_wr.delete();
        words.delete();
        for (int j = 0; j < 4; j++) words.push_back(vt[0].w[j]);
        run_core(vt[0].base, 4, 0, 1'b0, 1'b0, 64'h1A, 1'b0);

        // Longer run with random words, random base and random host gaps.
        words.delete();
        m = '0;
        for (int j = 0; j < 20; j++) begin
            words.push_back({$urandom, $urandom});
            m = model_chk(m, words[j]);
        end
        rb = AW'($urandom_range(0, (1 << AW) - 1));
        run_core(rb, 20, 2, 1'b1, 1'b0, m, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_debug_loader.md
# mem_debug_loader

Host-side initiator for the processor's memory debug port: it streams a program/data image into the unified memory through the `setup_mem` write path, then reads the same range back through the `verify_mem` path and checks it against a running checksum. It holds the core disabled for the whole operation. It sits between a host word stream (UART/PCIe bridge side) and the core's `mem_addr_in`/`mem_data_in`/`setup_mem`/`verify_mem`/`mem_data_out` pins.

## Interface
- `ADDR_WIDTH`, 10: memory address width.
- `DATA_WIDTH`, 64: memory word width.
- `RD_LATENCY`, 1: cycles from address presented (with `verify_mem` high) to valid `mem_rdata_in`; must be ≥1.
- `clk`  in  1  the single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  one-cycle pulse; accepted only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first address; sampled on accepted `start`.
- `word_count`  in  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH; sampled on accepted `start`.
- `host_valid`  in  1  host word available.
- `host_ready`  out  1  loader accepts a word this cycle.
- `host_data`  in  DATA_WIDTH  host word.
- `mem_addr_out`  out  ADDR_WIDTH  to core `mem_addr_in`.
- `mem_wdata_out`  out  DATA_WIDTH  to core `mem_data_in`.
- `setup_mem`  out  1  write strobe, one cycle per word.
- `verify_mem`  out  1  read-port select.
- `mem_rdata_in`  in  DATA_WIDTH  from core `mem_data_out`.
- `core_en`  out  1  to core `en`; low while busy.
- `busy`  out  1  not in IDLE.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  checksum mismatch of the last run; sticky until the next accepted `start`.
- `checksum`  out  DATA_WIDTH  load-phase checksum of the last run.

## Operation
- FSM states: IDLE, LOAD, VERIFY, DRAIN, FINISH.
- IDLE: `core_en`=1. An accepted `start` clears `error`, `checksum`, and the counters, latches `base_addr`/`word_count`, and goes to LOAD. If `word_count`=0, it goes directly to FINISH.
- LOAD: `host_ready`=1. Each handshake (`host_valid`&&`host_ready`) registers `mem_addr_out`=base+i, `mem_wdata_out`=`host_data`, and `setup_mem`=1 for exactly one cycle. It also updates `chk_load = rotl1(chk_load) + host_data` (mod 2^DATA_WIDTH). After the word_count-th handshake: `host_ready` drops and the FSM goes to VERIFY.
- VERIFY: one address per cycle with `verify_mem`=1, i = 0..count-1, same base. A valid shift register of depth RD_LATENCY tags returned data, and each tagged `mem_rdata_in` updates `chk_read` with the same function. After the last address is issued, the FSM goes to DRAIN.
- DRAIN: `verify_mem` stays 1 until the last tagged datum is consumed, then the FSM goes to FINISH.
- FINISH: `error` = (chk_read != chk_load), `checksum` = chk_load, and `done`=1 for one cycle. The FSM then returns to IDLE.
- Address arithmetic: base+i mod 2^ADDR_WIDTH (wraps 0x3FF→0x000).
- `start` while busy is ignored.
- `host_valid` outside LOAD is ignored (`host_ready`=0).

## Timing
- Reset values: `host_ready`=0, `setup_mem`=0, `verify_mem`=0, `mem_addr_out`=0, `mem_wdata_out`=0, `core_en`=1, `busy`=0, `done`=0, `error`=0, `checksum`=0; state IDLE.
- `busy` and `core_en`=0 are asserted the cycle after the accepted `start`.
- A handshake at edge N puts `setup_mem` high in cycle N+1; the memory writes at edge N+2.
- Back-to-back handshakes give back-to-back write strobes.
- `setup_mem` and `verify_mem` are never high in the same cycle. The first VERIFY cycle follows the final `setup_mem` cycle.
- Verify-phase duration: count + RD_LATENCY cycles.
- Reset mid-operation: all outputs return to reset values immediately; any partial memory image is left as-is.

## Configuration
- `MEM_LOADER_VERIFY_EN` defined: the full LOAD→VERIFY→DRAIN→FINISH flow.
- `MEM_LOADER_VERIFY_EN` undefined: LOAD goes directly to FINISH; `verify_mem` is tied 0; `error` is tied 0; `mem_rdata_in` is unused. `checksum` is still reported.

## Structure
- Shared package `mem_loader_pkg` holds:
  - the FSM state enum;
  - the checksum update function (rotate-left-1 then add);
  - default width constants (10/64).
- Natural sub-module `mem_loader_rdpipe`: the RD_LATENCY-deep valid shift register plus the read-side checksum accumulator.

## Test plan
- Base 0x000, count 4, words 1,2,3,4, ideal 1-cycle memory → 4 single-cycle `setup_mem` strobes at 0..3, then 4 verify reads; `done` pulse, `error`=0, `checksum`=0x1A.
- Base 0x3FE, count 4 → write and verify addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Memory model flips bit 0 of the word at address 2 on readback → `error`=1, `checksum`=0x1A; `error` clears on the next `start`.
- `host_valid` toggling 1,0,0,1,… → one write per handshake, no strobe in gap cycles, same final checksum as the gap-free run.
- count 0 → no `setup_mem`/`verify_mem`; `done` two cycles after `start`; `checksum`=0, `error`=0.
- `reset` asserted after 2 of 4 words → outputs return to reset values immediately (`core_en`=1, `busy`=0); a new `start` runs cleanly.
